// File: rtl/unsadd_n.sv
// N-input non-scaled unary adder: emits a bitstream whose density tracks the
// clamped sum of the input densities, windowed over 2^WLEN cycles.
module unsadd_n #(
  parameter int NINPUT      = 2,
  parameter int WLEN        = 8,
  parameter bit DEF_BIPOLAR = 1'b1
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic              iClr,
  input  logic              iBipolar,
  input  logic [NINPUT-1:0] iA,
  output logic              oC,
  output logic              oSat,
  output logic              oWinDone,
  output logic [WLEN:0]     oCnt
);

  localparam int TW = WLEN + $clog2(NINPUT) + 3;
  localparam int PW = $clog2(NINPUT + 1);

  logic signed [TW-1:0] tgt;
  logic signed [TW-1:0] tgt_n;
  logic signed [TW-1:0] off;
  logic signed [TW:0]   diff;
  logic [WLEN:0]        cnt;
  logic [WLEN-1:0]      wcnt;
  logic                 mode_q;
  logic [PW-1:0]        pc;
  logic                 emit;
  logic                 sat;
  logic                 win_end;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NINPUT; i++) begin
      pc = pc + PW'(iA[i]);
    end
  end

  // Target is kept in half-units so the bipolar (NINPUT-1)/2 offset stays exact.
  always_comb begin
    off     = mode_q ? TW'(NINPUT - 1) : '0;
    tgt_n   = tgt + $signed(TW'({pc, 1'b0})) - off;
    diff    = $signed({tgt_n[TW-1], tgt_n}) - $signed((TW+1)'({cnt, 1'b0}));
    emit    = ~diff[TW] && (diff != '0);
    sat     = ~diff[TW] && (diff[TW-1:0] > TW'(2));
    win_end = (wcnt == {WLEN{1'b1}});
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      tgt      <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      mode_q   <= DEF_BIPOLAR;
      oC       <= 1'b0;
      oSat     <= 1'b0;
      oWinDone <= 1'b0;
    end else if (iClr) begin
      tgt      <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      mode_q   <= iBipolar;
      oC       <= 1'b0;
      oSat     <= 1'b0;
      oWinDone <= 1'b0;
    end else if (iEn) begin
      oC   <= emit;
      oSat <= sat;
      // Window end discards any backlog, positive or negative.
      if (win_end) begin
        tgt      <= '0;
        cnt      <= '0;
        wcnt     <= '0;
        mode_q   <= iBipolar;
        oWinDone <= 1'b1;
      end else begin
        tgt      <= tgt_n;
        cnt      <= cnt + (WLEN+1)'(emit);
        wcnt     <= wcnt + 1'b1;
        oWinDone <= 1'b0;
      end
    end else begin
      oC       <= 1'b0;
      oSat     <= 1'b0;
      oWinDone <= 1'b0;
    end
  end

  assign oCnt = cnt;

endmodule

// File: tb/tb_unsadd_n.sv
// Scoreboard bench for unsadd_n: a behavioural model pushes expected outputs
// per driven cycle, which are popped and compared after the clock edge.
module tb_unsadd_n;

  localparam int NI = 2;
  localparam int WL = 8;
  localparam int WIN = 2 ** WL;

  logic          iClk;
  logic          iRstN;
  logic          iEn;
  logic          iClr;
  logic          iBipolar;
  logic [NI-1:0] iA;
  logic          oC;
  logic          oSat;
  logic          oWinDone;
  logic [WL:0]   oCnt;

  typedef struct {
    int c;
    int sat;
    int done;
    int cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  int m_tgt;
  int m_cnt;
  int m_win;
  bit m_mode;

  unsadd_n #(
    .NINPUT(NI),
    .WLEN(WL),
    .DEF_BIPOLAR(1'b1)
  ) dut (
    .iClk(iClk),
    .iRstN(iRstN),
    .iEn(iEn),
    .iClr(iClr),
    .iBipolar(iBipolar),
    .iA(iA),
    .oC(oC),
    .oSat(oSat),
    .oWinDone(oWinDone),
    .oCnt(oCnt)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
    n_fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic modelReset();
    m_tgt  = 0;
    m_cnt  = 0;
    m_win  = 0;
    m_mode = 1'b1;
    sb.delete();
  endtask

  // Reference behaviour: integer half-unit target against twice the emitted count.
  task automatic modelStep(input logic [NI-1:0] a, input bit en, input bit clr,
                           input bit bip, output exp_t e);
    int t_next;
    int d;
    e = '{c: 0, sat: 0, done: 0, cnt: 0};
    if (clr) begin
      m_tgt  = 0;
      m_cnt  = 0;
      m_win  = 0;
      m_mode = bip;
    end else if (en) begin
      t_next = m_tgt + 2 * $countones(a) - (m_mode ? NI - 1 : 0);
      d      = t_next - 2 * m_cnt;
      e.c    = (d > 0) ? 1 : 0;
      e.sat  = (d > 2) ? 1 : 0;
      if (m_win == WIN - 1) begin
        m_tgt  = 0;
        m_cnt  = 0;
        m_win  = 0;
        m_mode = bip;
        e.done = 1;
      end else begin
        m_tgt = t_next;
        m_cnt = m_cnt + e.c;
        m_win = m_win + 1;
      end
    end
    e.cnt = m_cnt;
  endtask

  task automatic applyStimulus(input logic [NI-1:0] a, input bit en, input bit clr, input bit bip);
    exp_t e;
    iA       = a;
    iEn      = en;
    iClr     = clr;
    iBipolar = bip;
    modelStep(a, en, clr, bip, e);
    sb.push_back(e);
    @(posedge iClk);
    #1;
    cyc++;
    e = sb.pop_front();
    checkOutput("oC", int'(oC), e.c);
    checkOutput("oSat", int'(oSat), e.sat);
    checkOutput("oWinDone", int'(oWinDone), e.done);
    checkOutput("oCnt", int'(oCnt), e.cnt);
  endtask

  initial begin
    int dones;
    int sat_hits;

    // Reset held with active inputs: outputs must stay at zero.
    iRstN    = 1'b0;
    iA       = 2'b11;
    iEn      = 1'b1;
    iClr     = 1'b0;
    iBipolar = 1'b0;
    modelReset();
    repeat (3) @(posedge iClk);
    #1;
    checkOutput("rst_oC", int'(oC), 0);
    checkOutput("rst_oSat", int'(oSat), 0);
    checkOutput("rst_oWinDone", int'(oWinDone), 0);
    checkOutput("rst_oCnt", int'(oCnt), 0);
    @(negedge iClk);
    iRstN = 1'b1;

    // Bipolar half-density input: alternating output, one window pulse.
    $display("[TB] bipolar 01 window");
    dones = 0;
    for (int i = 0; i < WIN; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
      if (i == 0) checkOutput("bip_first_oC", int'(oC), 1);
      if (i == 1) checkOutput("bip_second_oC", int'(oC), 0);
      if (i == WIN - 2) checkOutput("bip_cnt_last", int'(oCnt), 128);
      if (oWinDone) dones++;
    end
    checkOutput("bip_done_last", int'(oWinDone), 1);
    checkOutput("bip_cnt_after", int'(oCnt), 0);
    checkOutput("bip_done_count", dones, 1);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("bip_done_drop", int'(oWinDone), 0);

    // Unipolar saturation: every cycle emits, demand exceeds one bit.
    $display("[TB] unipolar 11 window");
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    sat_hits = 0;
    for (int i = 0; i < WIN; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      if (i == 0) checkOutput("uni_first_sat", int'(oSat), 1);
      if (i == WIN - 2) checkOutput("uni_cnt_last", int'(oCnt), 255);
      if (oSat) sat_hits++;
    end
    checkOutput("uni_sat_count", sat_hits, WIN);
    checkOutput("uni_done", int'(oWinDone), 1);

    // Negative backlog must be discarded at the window boundary.
    $display("[TB] bipolar backlog window");
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < WIN; i++) begin
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
    end
    checkOutput("neg_done", int'(oWinDone), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
      if (i == 0) checkOutput("neg_next_oC", int'(oC), 1);
    end

    // Mid-window mode toggle, enable drop and clear.
    $display("[TB] mid-window control");
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 120; i++) begin
      if (i >= 100 && i < 110) begin
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_oC", int'(oC), 0);
      end else begin
        applyStimulus(2'b01, 1'b1, 1'b0, (i < 50) ? 1'b1 : 1'b0);
        if (i > 50 && i < 100) checkOutput("toggle_pattern", int'(oC), (i % 2 == 0) ? 1 : 0);
      end
    end
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b1);
    checkOutput("clr_oCnt", int'(oCnt), 0);
    dones = 0;
    for (int i = 0; i < WIN; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
      if (oWinDone) dones++;
    end
    checkOutput("clr_done_last", int'(oWinDone), 1);
    checkOutput("clr_done_count", dones, 1);

    // Asynchronous reset 77 cycles into a window.
    $display("[TB] async reset mid-window");
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 77; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    end
    iRstN = 1'b0;
    #1;
    checkOutput("arst_oC", int'(oC), 0);
    checkOutput("arst_oSat", int'(oSat), 0);
    checkOutput("arst_oWinDone", int'(oWinDone), 0);
    checkOutput("arst_oCnt", int'(oCnt), 0);
    modelReset();
    @(negedge iClk);
    iRstN = 1'b1;
    dones = 0;
    for (int i = 0; i < WIN; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
      if (oWinDone) dones++;
    end
    checkOutput("arst_done_last", int'(oWinDone), 1);
    checkOutput("arst_done_count", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
